// File: rtl/cphy_pkg.sv
// C-PHY word mapper shared definitions.
//   SYM_N          : number of wire-state symbols per 16-bit word
//   sym_t          : one symbol's attributes {flip, rot, pol}
//   FLIP_PAIR_MASK : 7-bit flip masks for the two-flip case, indexed by D[13:10]
package cphy_pkg;

  localparam int SYM_N = 7;

  typedef struct packed {
    logic flip;
    logic rot;
    logic pol;
  } sym_t;

  // Bit k set means symbol k is a flip symbol.
  localparam logic [0:15][SYM_N-1:0] FLIP_PAIR_MASK = '{
    7'b0000011,  // 0  : (0,1)
    7'b0000101,  // 1  : (0,2)
    7'b0000110,  // 2  : (1,2)
    7'b0001001,  // 3  : (0,3)
    7'b0001010,  // 4  : (1,3)
    7'b0001100,  // 5  : (2,3)
    7'b0010001,  // 6  : (0,4)
    7'b0010010,  // 7  : (1,4)
    7'b0010100,  // 8  : (2,4)
    7'b0011000,  // 9  : (3,4)
    7'b0100001,  // 10 : (0,5)
    7'b0100010,  // 11 : (1,5)
    7'b0100100,  // 12 : (2,5)
    7'b0101000,  // 13 : (3,5)
    7'b0110000,  // 14 : (4,5)
    7'b1010000   // 15 : (4,6)
  };

endpackage

// File: rtl/mapper_place.sv
// Combinational payload placement.
//   flipMask : bit k set -> symbol k is a flip symbol (rot=pol=0)
//   payload  : 2-bit {R,P} pairs, pair j = payload[2j+1:2j]
//   symbols  : the 7 resulting symbols
// Payload pairs fill the non-flip symbols in ascending index order.
module mapper_place
  import cphy_pkg::*;
(
  input  logic [SYM_N-1:0]            flipMask,
  input  logic [13:0]                 payload,
  output sym_t [SYM_N-1:0]            symbols
);

  logic [2:0] slot;

  always_comb begin
    slot    = 3'd0;
    symbols = '0;
    for (int k = 0; k < SYM_N; k++) begin
      if (flipMask[k]) begin
        symbols[k].flip = 1'b1;
      end else begin
        // slot counts non-flip symbols below k, i.e. the next payload pair
        {symbols[k].rot, symbols[k].pol} = payload[{slot, 1'b0} +: 2];
        slot = slot + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mapper.sv
// C-PHY TX word mapper: 16-bit word -> 7 symbols, registered (1-cycle latency).
//   clk        : system clock
//   rst        : synchronous reset, active-high, clears all outputs
//   TxData     : word to map, sampled every rising edge
//   TxRotation : bit k = Rotation of symbol k
//   TxPolarity : bit k = Polarity of symbol k
//   TxFlip     : bit k = Flip of symbol k
module mapper
  import cphy_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      TxData,
  output logic [SYM_N-1:0] TxRotation,
  output logic [SYM_N-1:0] TxPolarity,
  output logic [SYM_N-1:0] TxFlip
);

  logic [SYM_N-1:0] flipMask;
  logic [13:0]      payload;
  sym_t [SYM_N-1:0] symbols;

  always_comb begin
    flipMask = '0;
    payload  = '0;
    unique case (TxData[15:14])
      2'b00: begin
        payload = TxData[13:0];
      end
      2'b01: begin
        flipMask = 7'b0000001 << {1'b0, TxData[13:12]};
        payload  = {2'b00, TxData[11:0]};
      end
      2'b10: begin
        if (TxData[13:12] == 2'b11) begin
          // D[11:10] is not carried in this sub-case
          flipMask = 7'b1100000;
          payload  = {4'b0000, TxData[9:0]};
        end else begin
          flipMask = 7'b0010000 << {1'b0, TxData[13:12]};
          payload  = {2'b00, TxData[11:0]};
        end
      end
      2'b11: begin
        flipMask = FLIP_PAIR_MASK[TxData[13:10]];
        payload  = {4'b0000, TxData[9:0]};
      end
      default: begin
        flipMask = '0;
        payload  = '0;
      end
    endcase
  end

  mapper_place uPlace (
    .flipMask (flipMask),
    .payload  (payload),
    .symbols  (symbols)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      TxRotation <= '0;
      TxPolarity <= '0;
      TxFlip     <= '0;
    end else begin
      for (int k = 0; k < SYM_N; k++) begin
        TxRotation[k] <= symbols[k].rot;
        TxPolarity[k] <= symbols[k].pol;
        TxFlip[k]     <= symbols[k].flip;
      end
    end
  end

endmodule

// File: tb/tb_mapper.sv
// Self-checking bench for mapper: reset, directed words, exhaustive sweep
// against an independent reference model, streamed through a scoreboard queue.
module tb_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] TxData;
  logic [6:0]  TxRotation;
  logic [6:0]  TxPolarity;
  logic [6:0]  TxFlip;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;
    logic [6:0]  r;
    logic [6:0]  p;
    logic [6:0]  f;
    bit          sweep;
  } exp_t;

  exp_t expQ[$];

  int pairA[16] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 3, 4, 4};
  int pairB[16] = '{1, 2, 2, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 5, 5, 6};

  mapper dut (
    .clk        (clk),
    .rst        (rst),
    .TxData     (TxData),
    .TxRotation (TxRotation),
    .TxPolarity (TxPolarity),
    .TxFlip     (TxFlip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s data=%h got=%h want=%h", tag, TxData, got, want);
    end
  endtask

  function automatic void refMap(input logic [15:0] d, output logic [6:0] r,
                                 output logic [6:0] p, output logic [6:0] f);
    logic [13:0] pl;
    int n;
    f  = '0;
    pl = '0;
    case (d[15:14])
      2'b00: pl = d[13:0];
      2'b01: begin
        f[d[13:12]] = 1'b1;
        pl = {2'b00, d[11:0]};
      end
      2'b10: begin
        if (d[13:12] == 2'b11) begin
          f[5] = 1'b1;
          f[6] = 1'b1;
          pl = {4'b0, d[9:0]};
        end else begin
          f[4 + int'(d[13:12])] = 1'b1;
          pl = {2'b00, d[11:0]};
        end
      end
      default: begin
        f[pairA[d[13:10]]] = 1'b1;
        f[pairB[d[13:10]]] = 1'b1;
        pl = {4'b0, d[9:0]};
      end
    endcase
    r = '0;
    p = '0;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      if (!f[k]) begin
        r[k] = pl[2*n+1];
        p[k] = pl[2*n];
        n++;
      end
    end
  endfunction

  function automatic int flipCount(input logic [15:0] d);
    case (d[15:14])
      2'b00:   return 0;
      2'b01:   return 1;
      2'b10:   return (d[13:12] == 2'b11) ? 2 : 1;
      default: return 2;
    endcase
  endfunction

  task automatic popCheck();
    exp_t e;
    logic [13:0] packed14;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      chk("rot", {9'b0, TxRotation}, {9'b0, e.r});
      chk("pol", {9'b0, TxPolarity}, {9'b0, e.p});
      chk("flip", {9'b0, TxFlip}, {9'b0, e.f});
      if (e.sweep) begin
        chk("legal", {9'b0, TxFlip & (TxRotation | TxPolarity)}, 16'h0000);
        chk("nflip", 16'($countones(TxFlip)), 16'(flipCount(e.d)));
        if (e.d[15:14] == 2'b00) begin
          for (int k = 0; k < 7; k++) begin
            packed14[2*k+1] = TxRotation[k];
            packed14[2*k]   = TxPolarity[k];
          end
          chk("ident", {2'b0, packed14}, {2'b0, e.d[13:0]});
        end
      end
    end
  endtask

  task automatic stepWord(input logic [15:0] d, input logic [6:0] r,
                          input logic [6:0] p, input logic [6:0] f, input bit sweep);
    @(negedge clk);
    popCheck();
    TxData = d;
    expQ.push_back('{d: d, r: r, p: p, f: f, sweep: sweep});
  endtask

  logic [15:0] dirD[5] = '{16'h000F, 16'h6025, 16'h912A, 16'hC819, 16'hFFF0};
  logic [6:0]  dirR[5] = '{7'b0000011, 7'b0001000, 7'b0000111, 7'b0001000, 7'b0101100};
  logic [6:0]  dirP[5] = '{7'b0000011, 7'b0000011, 7'b0010000, 7'b0010001, 7'b0101100};
  logic [6:0]  dirF[5] = '{7'b0000000, 7'b0000100, 7'b0100000, 7'b0000110, 7'b1010000};

  initial begin
    logic [6:0] r, p, f;
    rst    = 1'b1;
    TxData = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rot", {9'b0, TxRotation}, 16'h0000);
    chk("rst_pol", {9'b0, TxPolarity}, 16'h0000);
    chk("rst_flip", {9'b0, TxFlip}, 16'h0000);

    // First mapping after reset release: FFFF -> flips (4,6), all payload ones.
    rst = 1'b0;
    expQ.push_back('{d: 16'hFFFF, r: 7'b0101111, p: 7'b0101111, f: 7'b1010000, sweep: 1'b0});

    for (int i = 0; i < 5; i++)
      stepWord(dirD[i], dirR[i], dirP[i], dirF[i], 1'b0);

    for (int w = 0; w < 65536; w++) begin
      refMap(16'(w), r, p, f);
      stepWord(16'(w), r, p, f, 1'b1);
    end

    @(negedge clk);
    popCheck();
    chk("queue_empty", 16'(expQ.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
